hamming_encoder_stream: RTL and testbench
=========================================

Name: hamming_encoder_stream

Overview:
Parametrised, streaming Hamming encoder for the link datapath. Accepts K-bit data words on a valid/ready input and emits N-bit codewords on a valid/ready output, at one word per cycle sustained. Internally it uses a registered output stage plus a one-entry skid buffer, so in_ready never depends combinationally on out_ready. Generalises the fixed (7,4) combinational encoder to any P, and adds a codeword counter.

Parameters:
P, 3, number of Hamming parity bits; valid range 3..6.
K, 2**P - P - 1 (derived localparam, not overridable), data width.
N, 2**P - 1, plus 1 when HAMMING_SECDED_EN is defined (derived localparam), codeword width.
CW, 16, width of the word_count output.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  K  data word
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts a word this cycle; registered output
out_msg  output  N  encoded codeword
out_valid  output  1  out_msg is valid
out_ready  input  1  downstream accepts out_msg
word_count  output  CW  number of codewords accepted downstream, modulo 2**CW

Behaviour:
- Codeword layout: msg bit i holds Hamming position i+1.
  - Positions that are powers of two (1, 2, 4, ...) carry parity bits p0..p(P-1).
  - Data bits fill the remaining positions in ascending order, starting with data[0] at position 3.
- Parity: pj = XOR of all data bits whose position has bit j set (even parity). For P=3 the codeword is {d3,d2,d1,p2,d0,p1,p0}.
- Encoding is combinational on the input side. Registers hold encoded codewords, not raw data.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_msg must stay stable while out_valid && !out_ready.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: output register full, skid empty, out_valid=1, in_ready=1.
  - TWO: output register and skid both full, out_valid=1, in_ready=0.
- Transitions:
  - EMPTY --in xfer--> ONE.
  - ONE --in xfer, no out xfer--> TWO (new word goes to skid).
  - ONE --out xfer, no in xfer--> EMPTY.
  - ONE --both--> ONE (new word goes to output register).
  - TWO --out xfer--> ONE (skid moves to output register).
  - All other cases hold state.
- Latency: a word accepted in cycle t appears on out_msg in cycle t+1 when the block was EMPTY. Throughput is 1 word/cycle while out_ready=1.
- Ordering is strict FIFO. No word is dropped or duplicated.
- word_count increments by 1 on each output transfer and wraps from 2**CW-1 to 0.
- Reset (asynchronous, any time, including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1, out_msg=0, word_count=0.
  - Skid contents are discarded.
- in_ready is forced to 0 while rst is high.
- in_data is ignored when in_valid=0. X on in_data with in_valid=0 must not propagate to out_msg.

Optional Feature:
HAMMING_SECDED_EN
- Defined: N = 2**P. msg[N-1] = XOR of msg[N-2:0], giving even overall parity and a SECDED extended code.
- Undefined: N = 2**P - 1. No overall parity bit is generated.
- Handshake, latency and word_count behaviour are identical in both builds.

Test Plan:
- P=3, no macro, reset, then in_data=4'b1011 with in_valid=1 and out_ready=1 -> out_msg=7'h55 one cycle later, out_valid=1, word_count=1.
- P=3 with HAMMING_SECDED_EN, in_data=4'b0001 -> out_msg=8'h87; in_data=4'b1011 -> out_msg=8'h55.
- P=4, in_data=11'h001 -> out_msg=15'h0007. Exhaustively check all 2048 inputs against the position-based parity model.
- Backpressure:
  - Hold out_ready=0 and push 3 words -> in_ready drops after 2 accepted, out_msg stays stable.
  - Release out_ready -> both words drain in order, in_ready returns to 1 the cycle after the first drain.
- Random in_valid/out_ready, 10k words -> scoreboard shows no loss, duplication or reordering, and word_count matches transfers mod 2**CW. With CW=4, the count wraps 15->0.
- Assert rst asynchronously mid-cycle while in state TWO -> out_valid=0, word_count=0, in_ready=1 immediately after reset deasserts; no stale word is emitted.

Source files
------------

// File: rtl/hamming_encoder_stream.sv
// hamming_encoder_stream
//   Streaming Hamming encoder: K-bit data words in, N-bit codewords out, one
//   word per cycle sustained. A registered output stage plus a one-entry skid
//   buffer keeps in_ready independent of out_ready in the same cycle.
//   Codeword bit i carries Hamming position i+1. Power-of-two positions hold
//   parity bits p0..p(P-1); data fills the other positions in ascending order.
//
//   Build option: define HAMMING_SECDED_EN to append an overall even-parity
//   bit as msg[N-1] (SECDED extended code, N = 2**P). Undefined: N = 2**P-1.
//
// Parameters:
//   P  - number of Hamming parity bits (3..6)
//   CW - width of word_count
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_data    - K-bit data word
//   in_valid   - in_data is valid
//   in_ready   - block accepts a word this cycle (registered, low during rst)
//   out_msg    - N-bit encoded codeword
//   out_valid  - out_msg is valid
//   out_ready  - downstream accepts out_msg
//   word_count - codewords accepted downstream, modulo 2**CW
module hamming_encoder_stream #(
    parameter int P  = 3,
    parameter int CW = 16,
    localparam int K = 2**P - P - 1,
`ifdef HAMMING_SECDED_EN
    localparam int N = 2**P
`else
    localparam int N = 2**P - 1
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [K-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out_msg,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] word_count
);

    localparam int unsigned NB = 2**P - 1;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  out_msg_q, out_msg_d;
    logic [N-1:0]  skid_q, skid_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic [CW-1:0] word_count_q, word_count_d;

    logic [K-1:0]  enc_data;
    logic [NB-1:0] base;
    logic [N-1:0]  enc_word;
    logic          par;
    int unsigned   di;
    logic          in_xfer, out_xfer;

    // Encoder. Data is gated by in_valid so an undriven in_data never
    // reaches the registers.
    always_comb begin
        enc_data = in_valid ? in_data : '0;
        base     = '0;
        di       = 0;
        for (int unsigned pos = 1; pos <= NB; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                base[pos-1] = enc_data[di];
                di          = di + 1;
            end
        end
        // Parity slots are still zero here, and no other power-of-two
        // position has bit j set, so each pj covers data bits only.
        for (int unsigned j = 0; j < P; j++) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos <= NB; pos++) begin
                if (pos[j]) par = par ^ base[pos-1];
            end
            base[(1 << j) - 1] = par;
        end
`ifdef HAMMING_SECDED_EN
        enc_word = {^base, base};
`else
        enc_word = base;
`endif
    end

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        out_msg_d    = out_msg_q;
        skid_d       = skid_q;
        word_count_d = word_count_q + CW'(out_xfer);
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_msg_d = enc_word;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    skid_d  = enc_word;
                    state_d = TWO;
                end else if (out_xfer && !in_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    out_msg_d = enc_word;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    out_msg_d = skid_q;
                    state_d   = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_msg_q    <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            out_msg_q    <= out_msg_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = in_ready_q && !rst;
    assign out_msg    = out_msg_q;
    assign out_valid  = out_valid_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_hamming_encoder_stream.sv
module tb_hamming_encoder_stream;

`ifdef HAMMING_SECDED_EN
    localparam int N3 = 8;
    localparam int N4 = 16;
    localparam bit SEC = 1'b1;
`else
    localparam int N3 = 7;
    localparam int N4 = 15;
    localparam bit SEC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // P=3, CW=4 instance: directed, backpressure, random, reset tests
    logic [3:0]    in_data3;
    logic          in_valid3, in_ready3, out_valid3, out_ready3;
    logic [N3-1:0] out_msg3;
    logic [3:0]    wc3;

    // P=4, CW=16 instance: exhaustive encoding check
    logic [10:0]   in_data4;
    logic          in_valid4, in_ready4, out_valid4, out_ready4;
    logic [N4-1:0] out_msg4;
    logic [15:0]   wc4;

    hamming_encoder_stream #(.P(3), .CW(4)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_msg(out_msg3), .out_valid(out_valid3),
        .out_ready(out_ready3), .word_count(wc3)
    );

    hamming_encoder_stream #(.P(4), .CW(16)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .out_msg(out_msg4), .out_valid(out_valid4),
        .out_ready(out_ready4), .word_count(wc4)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder: data bit i lands at the i-th non-power-of-two
    // position; the parity vector equals the XOR of positions of set data bits.
    function automatic logic [63:0] model_enc(input int p, input logic [63:0] d);
        logic [63:0] cw;
        int unsigned pos, syn, k, nb;
        cw  = '0;
        syn = 0;
        k   = (1 << p) - p - 1;
        nb  = (1 << p) - 1;
        pos = 2;
        for (int unsigned i = 0; i < k; i++) begin
            pos = pos + 1;
            while ((pos & (pos - 1)) == 0) pos = pos + 1;
            if (d[i]) begin
                cw[pos-1] = 1'b1;
                syn = syn ^ pos;
            end
        end
        for (int j = 0; j < p; j++) cw[(1 << j) - 1] = syn[j];
        if (SEC) cw[nb] = ^cw;
        return cw;
    endfunction

    // Scoreboards
    logic [N3-1:0] q3[$];
    logic [N4-1:0] q4[$];
    logic [3:0]    cnt3 = '0;
    logic [15:0]   cnt4 = '0;
    logic [3:0]    prev_wc3 = '0;
    bit            wrap_seen = 1'b0;
    int unsigned   pushed3 = 0, popped3 = 0, pushed4 = 0, popped4 = 0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            check_eq("wc3", {60'b0, wc3}, {60'b0, cnt3});
            if (prev_wc3 == 4'hF && wc3 == 4'h0) wrap_seen = 1'b1;
            prev_wc3 = wc3;
            if (in_valid3 && in_ready3) begin
                e = model_enc(3, {60'b0, in_data3});
                q3.push_back(e[N3-1:0]);
                pushed3++;
            end
            if (out_valid3 && out_ready3) begin
                if (q3.size() == 0) check_eq("sb3_nonempty", 64'(q3.size() != 0), 64'd1);
                else check_eq("sb3_msg", {{(64-N3){1'b0}}, out_msg3}, {{(64-N3){1'b0}}, q3.pop_front()});
                cnt3 = cnt3 + 4'd1;
                popped3++;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            if (in_valid4 && in_ready4) begin
                e = model_enc(4, {53'b0, in_data4});
                q4.push_back(e[N4-1:0]);
                pushed4++;
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) check_eq("sb4_nonempty", 64'(q4.size() != 0), 64'd1);
                else check_eq("sb4_msg", {{(64-N4){1'b0}}, out_msg4}, {{(64-N4){1'b0}}, q4.pop_front()});
                check_eq("wc4", {48'b0, wc4}, {48'b0, cnt4});
                cnt4 = cnt4 + 16'd1;
                popped4++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc, start;
        logic [N3-1:0] held;

        rst = 1'b1;
        in_data3 = 'x; in_valid3 = 1'b0; out_ready3 = 1'b0;
        in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid3), 64'd0);
        check_eq("rst_in_ready_low", 64'(in_ready3), 64'd0);
        check_eq("rst_out_msg", 64'(out_msg3), 64'd0);
        check_eq("rst_wc", 64'(wc3), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready3), 64'd1);

        // X on in_data with in_valid=0 must not reach out_msg
        repeat (2) @(posedge clk);
        #1;
        check_eq("x_gated_msg", 64'(out_msg3), 64'd0);
        check_eq("x_gated_valid", 64'(out_valid3), 64'd0);

        // 4'b1011 -> 0x55 (overall parity 0 under SECDED)
        in_data3 = 4'b1011; in_valid3 = 1'b1; out_ready3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0; in_data3 = 'x;
        check_eq("d1011_valid", 64'(out_valid3), 64'd1);
        check_eq("d1011_msg", 64'(out_msg3), 64'h55);
        @(posedge clk); #1;
        check_eq("d1011_wc", 64'(wc3), 64'd1);
        check_eq("d1011_drained", 64'(out_valid3), 64'd0);

        // 4'b0001 -> 0x07, or 0x87 with overall parity
        in_data3 = 4'b0001; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0; in_data3 = 'x;
        check_eq("d0001_msg", 64'(out_msg3), SEC ? 64'h87 : 64'h07);
        @(posedge clk); #1;

        // Backpressure: two accepted, third held off, output stable
        out_ready3 = 1'b0; in_valid3 = 1'b1; in_data3 = 4'h3;
        @(posedge clk); #1;
        check_eq("bp_ready_after1", 64'(in_ready3), 64'd1);
        in_data3 = 4'h9;
        @(posedge clk); #1;
        in_data3 = 4'hC;
        held = out_msg3;
        check_eq("bp_ready_after2", 64'(in_ready3), 64'd0);
        check_eq("bp_head_msg", 64'(out_msg3), model_enc(3, 64'h3));
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("bp_ready_held", 64'(in_ready3), 64'd0);
            check_eq("bp_msg_stable", 64'(out_msg3), 64'(held));
        end
        in_valid3 = 1'b0; in_data3 = 'x; out_ready3 = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_ready_return", 64'(in_ready3), 64'd1);
        check_eq("bp_second_msg", 64'(out_msg3), model_enc(3, 64'h9));
        @(posedge clk); #1;
        check_eq("bp_drained", 64'(out_valid3), 64'd0);

        // Random traffic, 10k words
        start = pushed3;
        cyc = 0;
        while (pushed3 - start < 10000 && cyc < 40000) begin
            in_valid3  = ($urandom_range(0, 3) != 0);
            in_data3   = 4'($urandom);
            out_ready3 = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("rand_budget", 64'(pushed3 - start >= 10000), 64'd1);
        in_valid3 = 1'b0; in_data3 = 'x; out_ready3 = 1'b1;
        cyc = 0;
        while (q3.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("rand_sb_empty", 64'(q3.size()), 64'd0);
        check_eq("rand_pop_eq_push", 64'(popped3), 64'(pushed3));
        check_eq("wc_wrap_seen", 64'(wrap_seen), 64'd1);

        // Async reset mid-cycle while holding two words
        out_ready3 = 1'b0; in_valid3 = 1'b1; in_data3 = 4'h5;
        @(posedge clk); #1;
        in_data3 = 4'h6;
        @(posedge clk); #1;
        in_valid3 = 1'b0; in_data3 = 'x;
        check_eq("two_in_ready", 64'(in_ready3), 64'd0);
        check_eq("two_out_valid", 64'(out_valid3), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 64'(out_valid3), 64'd0);
        check_eq("arst_wc", 64'(wc3), 64'd0);
        check_eq("arst_out_msg", 64'(out_msg3), 64'd0);
        check_eq("arst_in_ready_low", 64'(in_ready3), 64'd0);
        q3.delete();
        cnt3 = '0;
        prev_wc3 = '0;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("arst_rel_in_ready", 64'(in_ready3), 64'd1);
        check_eq("arst_rel_out_valid", 64'(out_valid3), 64'd0);
        check_eq("arst_rel_wc", 64'(wc3), 64'd0);
        out_ready3 = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("arst_no_stale", 64'(out_valid3), 64'd0);
        end

        // P=4 directed then exhaustive
        @(posedge clk); #1;
        in_valid4 = 1'b1; in_data4 = 11'h001;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check_eq("p4_d001", 64'(out_msg4), SEC ? 64'h8007 : 64'h0007);
        for (int i = 0; i < 2048; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 11'(i);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("p4_all_pushed", 64'(pushed4), 64'd2049);
        check_eq("p4_all_popped", 64'(popped4), 64'd2049);
        check_eq("p4_sb_empty", 64'(q4.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
